dca_matrix_lsu_store_txn_gen: RTL and testbench



---
 rtl/dca_lsu_store_pkg.sv | 48 ++++
 rtl/dca_handshake_fork.sv | 47 ++++
 rtl/dca_matrix_lsu_store_txn_gen.sv | 137 +++++++++++++
 tb/tb_dca_matrix_lsu_store_txn_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_lsu_store_pkg.sv
// Shared definitions for the matrix-store transaction path.
// - AXI burst encoding, FSM state type
// - txn-info word layout: {is_last_row, is_first_row, alen[7:0], addr[BW_ADDR-1:0]}
// - helpers for awsize and burst length
package dca_lsu_store_pkg;

  typedef enum logic {
    StIdle,
    StIssue
  } store_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // txn-info field layout; the formatter stage unpacks with the same offsets
  localparam int unsigned TXN_ADDR_LSB = 0;
  localparam int unsigned TXN_ALEN_W   = 8;

  function automatic int unsigned txn_alen_lsb(int unsigned bw_addr);
    return bw_addr;
  endfunction

  function automatic int unsigned txn_first_bit(int unsigned bw_addr);
    return bw_addr + TXN_ALEN_W;
  endfunction

  function automatic int unsigned txn_last_bit(int unsigned bw_addr);
    return bw_addr + TXN_ALEN_W + 1;
  endfunction

  function automatic int unsigned txn_info_width(int unsigned bw_addr);
    return bw_addr + TXN_ALEN_W + 2;
  endfunction

  localparam int unsigned BW_TXN_INFO = txn_info_width(32);

  function automatic logic [2:0] calc_awsize(int unsigned bw_axi_data);
    return 3'($clog2(bw_axi_data / 8));
  endfunction

  // alen = ceil(row_bytes / beat_bytes) - 1 == (row_bytes - 1) >> log2(beat_bytes)
  function automatic logic [7:0] calc_alen(logic [31:0] num_col_m1, int unsigned elem_shift,
                                           int unsigned beat_shift);
    logic [31:0] row_bytes;
    row_bytes = (num_col_m1 + 32'd1) << elem_shift;
    return 8'((row_bytes - 32'd1) >> beat_shift);
  endfunction

endpackage

// File: rtl/dca_handshake_fork.sv
// Two-way valid/ready fork with per-branch done flags.
// Each branch raises valid until it has handshaked once; o_advance pulses in the
// cycle where both branches are (or become) done, which also clears the flags.
// Ports:
//   clk, rstnn          clock, async active-low reset
//   i_clear             synchronous flag clear (abort or new instruction)
//   i_active            fork is presenting a transfer
//   o_valid_a/i_ready_a branch A handshake
//   o_valid_b/i_ready_b branch B handshake
//   o_advance           both branches complete this cycle
module dca_handshake_fork (
  input  logic clk,
  input  logic rstnn,
  input  logic i_clear,
  input  logic i_active,
  output logic o_valid_a,
  input  logic i_ready_a,
  output logic o_valid_b,
  input  logic i_ready_b,
  output logic o_advance
);

  logic r_done_a;
  logic r_done_b;
  logic w_fire_a;
  logic w_fire_b;

  assign o_valid_a = i_active & ~r_done_a;
  assign o_valid_b = i_active & ~r_done_b;
  assign w_fire_a  = o_valid_a & i_ready_a;
  assign w_fire_b  = o_valid_b & i_ready_b;
  assign o_advance = i_active & (r_done_a | w_fire_a) & (r_done_b | w_fire_b);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else if (i_clear || o_advance) begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else begin
      if (w_fire_a) r_done_a <= 1'b1;
      if (w_fire_b) r_done_b <= 1'b1;
    end
  end

endmodule

// File: rtl/dca_matrix_lsu_store_txn_gen.sv
// Matrix-store transaction generator: walks the rows of one store instruction,
// issuing one AXI AW burst and one txn-info word per row. A row advances only
// once both handshakes have completed.
// Ports:
//   clk, rstnn                    clock, async active-low reset
//   i_clear                       synchronous abort to idle
//   i_inst_*/o_inst_ready         instruction handshake and fields
//   o_aw*/i_awready               AXI write-address channel
//   o_txn_valid/i_txn_ready       txn-info queue handshake
//   o_txn_info                    {is_last_row, is_first_row, alen, addr}
//   o_busy                        instruction in progress
module dca_matrix_lsu_store_txn_gen
  import dca_lsu_store_pkg::*;
#(
  parameter int unsigned BW_ADDR        = 32,
  parameter int unsigned BW_AXI_DATA    = 32,
  parameter int unsigned MATRIX_NUM_COL = 4,
  parameter int unsigned BW_ELEMENT     = 32,
  parameter int unsigned BW_NUM_ROW_M1  = 8,
  parameter int unsigned BW_NUM_COL_M1  = 8,
  parameter int unsigned BW_STRIDE_LS3  = 16
) (
  input  logic                               clk,
  input  logic                               rstnn,
  input  logic                               i_clear,
  input  logic                               i_inst_valid,
  output logic                               o_inst_ready,
  input  logic [BW_ADDR-1:0]                 i_inst_addr,
  input  logic [BW_STRIDE_LS3-1:0]           i_inst_stride_ls3,
  input  logic [BW_NUM_ROW_M1-1:0]           i_inst_num_row_m1,
  input  logic [BW_NUM_COL_M1-1:0]           i_inst_num_col_m1,
  output logic                               o_awvalid,
  input  logic                               i_awready,
  output logic [BW_ADDR-1:0]                 o_awaddr,
  output logic [7:0]                         o_awlen,
  output logic [2:0]                         o_awsize,
  output logic [1:0]                         o_awburst,
  output logic                               o_txn_valid,
  input  logic                               i_txn_ready,
  output logic [txn_info_width(BW_ADDR)-1:0] o_txn_info,
  output logic                               o_busy
);

  localparam int unsigned ELEM_SHIFT = $clog2(BW_ELEMENT / 8);
  localparam int unsigned BEAT_SHIFT = $clog2(BW_AXI_DATA / 8);
  localparam int unsigned ALEN_LSB   = txn_alen_lsb(BW_ADDR);
  localparam int unsigned FIRST_BIT  = txn_first_bit(BW_ADDR);
  localparam int unsigned LAST_BIT   = txn_last_bit(BW_ADDR);

  store_state_e             r_state;
  logic [BW_NUM_ROW_M1-1:0] r_row_cnt;
  logic [BW_NUM_ROW_M1-1:0] r_num_row_m1;
  logic [BW_ADDR-1:0]       r_cur_addr;
  logic [BW_STRIDE_LS3-1:0] r_stride_ls3;
  logic [7:0]               r_alen;

  logic               w_active;
  logic               w_accept;
  logic               w_advance;
  logic               w_last_row;
  logic [BW_ADDR-1:0] w_stride_bytes;

  assign w_active       = (r_state == StIssue);
  assign w_accept       = (r_state == StIdle) & i_inst_valid & ~i_clear;
  assign w_last_row     = (r_row_cnt == r_num_row_m1);
  assign w_stride_bytes = BW_ADDR'({r_stride_ls3, 3'b000});

  dca_handshake_fork u_fork (
    .clk       (clk),
    .rstnn     (rstnn),
    .i_clear   (i_clear | w_accept),
    .i_active  (w_active),
    .o_valid_a (o_awvalid),
    .i_ready_a (i_awready),
    .o_valid_b (o_txn_valid),
    .i_ready_b (i_txn_ready),
    .o_advance (w_advance)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state      <= StIdle;
      r_row_cnt    <= '0;
      r_num_row_m1 <= '0;
      r_cur_addr   <= '0;
      r_stride_ls3 <= '0;
      r_alen       <= '0;
    end else if (i_clear) begin
      r_state   <= StIdle;
      r_row_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_inst_valid) begin
            r_state      <= StIssue;
            r_row_cnt    <= '0;
            r_num_row_m1 <= i_inst_num_row_m1;
            r_cur_addr   <= i_inst_addr;
            r_stride_ls3 <= i_inst_stride_ls3;
            r_alen       <= calc_alen(32'(i_inst_num_col_m1), ELEM_SHIFT, BEAT_SHIFT);
          end
        end
        StIssue: begin
          if (w_advance) begin
            if (w_last_row) begin
              r_state <= StIdle;
            end else begin
              r_row_cnt  <= r_row_cnt + 1'b1;
              r_cur_addr <= r_cur_addr + w_stride_bytes;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_inst_ready = (r_state == StIdle);
  assign o_busy       = w_active;
  assign o_awaddr     = r_cur_addr;
  assign o_awlen      = r_alen;
  assign o_awsize     = calc_awsize(BW_AXI_DATA);
  assign o_awburst    = AXI_BURST_INCR;

  always_comb begin
    o_txn_info                              = '0;
    o_txn_info[TXN_ADDR_LSB +: BW_ADDR]     = r_cur_addr;
    o_txn_info[ALEN_LSB +: TXN_ALEN_W]      = r_alen;
    o_txn_info[FIRST_BIT]                   = (r_row_cnt == '0);
    o_txn_info[LAST_BIT]                    = w_last_row;
  end

  // Column count beyond the row buffer is a software error.
  a_ncol_in_range : assert property (@(posedge clk) disable iff (!rstnn)
    w_accept |-> (32'(i_inst_num_col_m1) < MATRIX_NUM_COL));

endmodule

// File: tb/tb_dca_matrix_lsu_store_txn_gen.sv
// Scoreboard bench: two DUT instances (32-bit and 64-bit AXI data) share one
// stimulus stream; expected AW and txn words are queued at issue and popped by
// negedge monitors whenever a handshake occurs.
module tb_dca_matrix_lsu_store_txn_gen;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        clear;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [15:0] inst_stride;
  logic [7:0]  inst_nrow;
  logic [7:0]  inst_ncol;
  logic        awready;
  logic        txn_ready;

  logic        a_inst_ready, a_awvalid, a_txn_valid, a_busy;
  logic [31:0] a_awaddr;
  logic [7:0]  a_awlen;
  logic [2:0]  a_awsize;
  logic [1:0]  a_awburst;
  logic [41:0] a_txn_info;
  logic        b_inst_ready, b_awvalid, b_txn_valid, b_busy;
  logic [31:0] b_awaddr;
  logic [7:0]  b_awlen;
  logic [2:0]  b_awsize;
  logic [1:0]  b_awburst;
  logic [41:0] b_txn_info;

  always #5 clk = ~clk;

  dca_matrix_lsu_store_txn_gen #(.BW_AXI_DATA(32)) u_dut_a (
    .clk(clk), .rstnn(rstnn), .i_clear(clear),
    .i_inst_valid(inst_valid), .o_inst_ready(a_inst_ready), .i_inst_addr(inst_addr),
    .i_inst_stride_ls3(inst_stride), .i_inst_num_row_m1(inst_nrow),
    .i_inst_num_col_m1(inst_ncol),
    .o_awvalid(a_awvalid), .i_awready(awready), .o_awaddr(a_awaddr), .o_awlen(a_awlen),
    .o_awsize(a_awsize), .o_awburst(a_awburst),
    .o_txn_valid(a_txn_valid), .i_txn_ready(txn_ready), .o_txn_info(a_txn_info),
    .o_busy(a_busy)
  );

  dca_matrix_lsu_store_txn_gen #(.BW_AXI_DATA(64)) u_dut_b (
    .clk(clk), .rstnn(rstnn), .i_clear(clear),
    .i_inst_valid(inst_valid), .o_inst_ready(b_inst_ready), .i_inst_addr(inst_addr),
    .i_inst_stride_ls3(inst_stride), .i_inst_num_row_m1(inst_nrow),
    .i_inst_num_col_m1(inst_ncol),
    .o_awvalid(b_awvalid), .i_awready(awready), .o_awaddr(b_awaddr), .o_awlen(b_awlen),
    .o_awsize(b_awsize), .o_awburst(b_awburst),
    .o_txn_valid(b_txn_valid), .i_txn_ready(txn_ready), .o_txn_info(b_txn_info),
    .o_busy(b_busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic        first;
    logic        last;
  } exp_t;

  exp_t aw_q_a[$], tx_q_a[$], aw_q_b[$], tx_q_b[$];

  int total = 0;
  int bad   = 0;
  int rows_pushed = 0;
  int aw_fires_a = 0, tx_fires_a = 0, aw_fires_b = 0, tx_fires_b = 0;
  logic toggle_txn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  exp_t e;
  logic        hold_aw_a = 1'b0, hold_tx_a = 1'b0, hold_aw_b = 1'b0;
  logic [31:0] held_aw_a, held_aw_b;
  logic [41:0] held_tx_a;

  always @(negedge clk) begin
    if (rstnn) begin
      // stability of presented-but-unaccepted transfers
      if (hold_aw_a) check("a_aw_hold", {a_awvalid, a_awaddr}, {1'b1, held_aw_a});
      if (hold_tx_a) check("a_txn_hold", {a_txn_valid, a_txn_info}, {1'b1, held_tx_a});
      if (hold_aw_b) check("b_aw_hold", {b_awvalid, b_awaddr}, {1'b1, held_aw_b});
      hold_aw_a = a_awvalid && !awready && !clear;
      hold_tx_a = a_txn_valid && !txn_ready && !clear;
      hold_aw_b = b_awvalid && !awready && !clear;
      held_aw_a = a_awaddr;
      held_tx_a = a_txn_info;
      held_aw_b = b_awaddr;

      if (a_awvalid && awready) begin
        aw_fires_a++;
        if (aw_q_a.size() == 0) check("a_aw_unexpected", 64'(a_awaddr), 64'hdead);
        else begin
          e = aw_q_a.pop_front();
          check("a_awaddr", 64'(a_awaddr), 64'(e.addr));
          check("a_awlen", 64'(a_awlen), 64'(e.alen));
          check("a_awsize", 64'(a_awsize), 64'd2);
          check("a_awburst", 64'(a_awburst), 64'd1);
        end
      end
      if (a_txn_valid && txn_ready) begin
        tx_fires_a++;
        if (tx_q_a.size() == 0) check("a_txn_unexpected", 64'(a_txn_info), 64'hdead);
        else begin
          e = tx_q_a.pop_front();
          check("a_txn_info", 64'(a_txn_info), 64'({e.last, e.first, e.alen, e.addr}));
        end
      end
      if (b_awvalid && awready) begin
        aw_fires_b++;
        if (aw_q_b.size() == 0) check("b_aw_unexpected", 64'(b_awaddr), 64'hdead);
        else begin
          e = aw_q_b.pop_front();
          check("b_awaddr", 64'(b_awaddr), 64'(e.addr));
          check("b_awlen", 64'(b_awlen), 64'(e.alen));
          check("b_awsize", 64'(b_awsize), 64'd3);
          check("b_awburst", 64'(b_awburst), 64'd1);
        end
      end
      if (b_txn_valid && txn_ready) begin
        tx_fires_b++;
        if (tx_q_b.size() == 0) check("b_txn_unexpected", 64'(b_txn_info), 64'hdead);
        else begin
          e = tx_q_b.pop_front();
          check("b_txn_info", 64'(b_txn_info), 64'({e.last, e.first, e.alen, e.addr}));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Issues one instruction; expectations pushed for the first n_push rows.
  task automatic issue(input logic [31:0] addr, input logic [15:0] stride, input int nrow_m1,
                       input logic [7:0] ncol_m1, input logic [7:0] alen32,
                       input logic [7:0] alen64, input int n_push);
    exp_t x;
    logic [31:0] ra;
    int waited = 0;
    while (!a_inst_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("inst_ready_before_issue", 64'(a_inst_ready), 64'd1);
    inst_addr   = addr;
    inst_stride = stride;
    inst_nrow   = 8'(nrow_m1);
    inst_ncol   = ncol_m1;
    inst_valid  = 1'b1;
    ra = addr;
    for (int r = 0; r < n_push; r++) begin
      x.addr  = ra;
      x.first = (r == 0);
      x.last  = (r == nrow_m1);
      x.alen  = alen32;
      aw_q_a.push_back(x);
      tx_q_a.push_back(x);
      x.alen  = alen64;
      aw_q_b.push_back(x);
      tx_q_b.push_back(x);
      ra = ra + {13'd0, stride, 3'b000};
      rows_pushed++;
    end
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((a_busy || b_busy || aw_q_a.size() != 0 || tx_q_a.size() != 0 ||
            aw_q_b.size() != 0 || tx_q_b.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      if (toggle_txn) txn_ready = ~txn_ready;
      n++;
    end
    check({name, "_drained"}, 64'(n < 200), 64'd1);
    check({name, "_queues_empty"},
          64'(aw_q_a.size() + tx_q_a.size() + aw_q_b.size() + tx_q_b.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rstnn = 1'b1; clear = 1'b0; inst_valid = 1'b0; inst_addr = '0; inst_stride = '0;
    inst_nrow = '0; inst_ncol = '0; awready = 1'b1; txn_ready = 1'b1;
    #2 rstnn = 1'b0;
    #1;
    check("rst_awvalid", 64'(a_awvalid), 64'd0);
    check("rst_txn_valid", 64'(a_txn_valid), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_inst_ready", 64'(a_inst_ready), 64'd1);
    check("rst_b_awvalid", 64'(b_awvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstnn = 1'b1;
    @(posedge clk); #1;

    // 1 row, 4 x 32-bit columns at 0x1000
    issue(32'h1000, 16'd0, 0, 8'd3, 8'd3, 8'd1, 1);
    check("t1_inst_ready_busy", 64'(a_inst_ready), 64'd0);
    check("t1_busy", 64'(a_busy), 64'd1);
    check("t1_awvalid_after_accept", 64'({a_awvalid, a_txn_valid}), 64'b11);
    @(posedge clk); #1;
    check("t1_inst_ready_back", 64'(a_inst_ready), 64'd1);
    check("t1_busy_clear", 64'(a_busy), 64'd0);
    drain("t1");

    // 3 rows, 3 columns, stride 32 bytes
    issue(32'h2000, 16'd4, 2, 8'd2, 8'd2, 8'd1, 3);
    drain("t2");

    // AW stalled 5 cycles while txn accepts immediately
    awready = 1'b0;
    issue(32'h7000, 16'd2, 1, 8'd1, 8'd1, 8'd0, 2);
    @(posedge clk); #1;
    check("t3_txn_dropped", 64'({a_awvalid, a_txn_valid}), 64'b10);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t3_no_advance", 64'(a_awaddr), 64'h7000);
    check("t3_txn_still_low", 64'(a_txn_valid), 64'd0);
    awready = 1'b1;
    @(posedge clk); #1;
    check("t3_advanced_addr", 64'(a_awaddr), 64'h7010);
    check("t3_row1_valids", 64'({a_awvalid, a_txn_valid}), 64'b11);
    drain("t3");

    // txn_ready toggling every cycle
    toggle_txn = 1'b1;
    issue(32'h4000, 16'd8, 2, 8'd3, 8'd3, 8'd1, 3);
    drain("t4");
    toggle_txn = 1'b0;
    txn_ready  = 1'b1;

    // address wrap
    issue(32'hFFFF_FFF0, 16'd2, 1, 8'd1, 8'd1, 8'd0, 2);
    drain("t5");

    // clear during row 1 of 4
    issue(32'h5000, 16'd1, 3, 8'd0, 8'd0, 8'd0, 1);
    @(posedge clk); #1;
    awready = 1'b0; txn_ready = 1'b0;
    @(posedge clk); #1;
    check("t6_row1_presented", 64'(a_awaddr), 64'h5008);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t6_valids_dropped", 64'({a_awvalid, a_txn_valid, b_awvalid, b_txn_valid}), 64'd0);
    check("t6_busy", 64'(a_busy), 64'd0);
    check("t6_inst_ready", 64'(a_inst_ready), 64'd1);
    awready = 1'b1; txn_ready = 1'b1;
    issue(32'h6000, 16'd0, 0, 8'd0, 8'd0, 8'd0, 1);
    drain("t6");

    check("aw_fires_a", 64'(aw_fires_a), 64'(rows_pushed));
    check("tx_fires_a", 64'(tx_fires_a), 64'(rows_pushed));
    check("aw_fires_b", 64'(aw_fires_b), 64'(rows_pushed));
    check("tx_fires_b", 64'(tx_fires_b), 64'(rows_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
